regfile_writeback_arbiter: RTL and testbench
============================================

Name: regfile_writeback_arbiter

Overview:
Shares the single store port of the 32-entry register array between several result producers (ALU, load unit, CSR unit) using round-robin arbitration with a valid/ready handshake. Drives the array's store select, store value and write strobe from a registered writeback stage. Keeps a busy scoreboard so issue logic can stall on pending destination registers. Sits between the execute-stage producers and register_array.

Parameters:
NUM_REQ, 3, number of writeback requesters; index 0 is the highest priority after reset.
XLEN, 32, data width.
SELECT_LEN, 5, register index width.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  requester i has a result
req_ready  output  NUM_REQ  requester i accepted this cycle
req_rd  input  NUM_REQ*SELECT_LEN  destination index; slice i belongs to requester i
req_data  input  NUM_REQ*XLEN  result data; slice i belongs to requester i
mark_valid  input  1  issue stage reserves a destination
mark_rd  input  SELECT_LEN  register to mark busy
flush  input  1  clear the whole scoreboard
query_a  input  SELECT_LEN  source index A to check
query_b  input  SELECT_LEN  source index B to check
busy_a  output  1  query_a has a pending write
busy_b  output  1  query_b has a pending write
rf_we  output  1  store strobe to register array
rf_store  output  SELECT_LEN  store index to register array
rf_store_value  output  XLEN  store data to register array
busy_vec  output  32  full scoreboard, for debug

Behaviour:
- Reset (async, active-high): rf_we=0, rf_store=0, rf_store_value=0, scoreboard=0, round-robin pointer=0. All requests are dropped. Reset in the middle of a handshake means nothing is written.
- Arbitration (combinational): the first requester with req_valid=1, searching from the pointer upward modulo NUM_REQ, is granted. req_ready is one-hot or zero. The writeback stage never stalls, so req_ready=grant. req_ready does not depend on req_valid of the granted requester beyond the grant search.
- A handshake is req_valid[i] & req_ready[i]. On a handshake the pointer moves to (i+1) mod NUM_REQ. With no handshake, the pointer holds.
- Writeback stage: registered, latency 1. A handshake at edge N drives rf_store=req_rd[i] and rf_store_value=req_data[i] after edge N, with rf_we=1 only if req_rd[i]!=0.
  - An rd=0 request is accepted but produces rf_we=0.
  - With no handshake, rf_we=0 and rf_store/rf_store_value hold their previous values.
- Scoreboard: 32 bits; bit 0 is hard-wired to 0.
  - Set: mark_valid with mark_rd!=0 sets bit mark_rd at the next edge.
  - Clear: rf_we=1 clears bit rf_store at the edge that ends the rf_we cycle.
  - Same bit set and cleared in one cycle: set wins, because a new producer is pending.
  - flush clears all bits at the next edge. flush with mark_valid in the same cycle: the marked bit ends up set. An in-flight rf_we still writes.
- Unmarked writes (the scoreboard bit is already 0) are legal and write normally.
- busy_a = scoreboard[query_a] and busy_b = scoreboard[query_b], combinational. A query of index 0 always returns 0.
- Starvation bound: a requester holding req_valid is granted within NUM_REQ cycles.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: adds outputs fwd_a_valid, fwd_b_valid (1 bit each) and fwd_a_data, fwd_b_data (XLEN each). When rf_we=1 and rf_store equals query_a (nonzero), busy_a=0, fwd_a_valid=1 and fwd_a_data=rf_store_value. Port B behaves the same way. At all other times fwd_*_valid=0 and fwd_*_data=0.
- Not defined: these ports do not exist. busy stays 1 throughout the rf_we cycle, and the consumer reads the array in the following cycle.

Test Plan:
- Reset and single write: after reset deassert, mark rd=5 → busy_vec[5]=1. Requester 1 sends rd=5, data 0xDEADBEEF → req_ready[1]=1 the same cycle; next cycle rf_we=1, rf_store=5, rf_store_value=0xDEADBEEF; the cycle after that, busy_vec[5]=0.
- Round-robin: all three req_valid held high with rd=1,2,3 → grants 0,1,2,0,… on consecutive cycles; rf_store sequence 1,2,3,1.
- x0 discard: mark rd=0 → busy_vec stays 0. Request rd=0 with data 0x1234 → req_ready=1, rf_we stays 0.
- Set/clear collision: rf_we=1 for rd=7 while mark_valid with mark_rd=7 in the same cycle → busy_vec[7]=1 afterwards. A flush together with a mark of rd=9 → only bit 9 set.
- Async reset mid-stream: assert reset between clock edges while a request is granted → rf_we=0 and busy_vec=0 immediately; after release, requester 0 is granted first.
- Bypass (WB_BYPASS_EN): rf_we=1, rf_store=4, value 0x55; query_a=4 → busy_a=0, fwd_a_valid=1, fwd_a_data=0x55. Without the macro, busy_a=1 in that cycle.

Source files
------------

// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
// Round-robin arbiter that shares the single store port of the register array
// between the result producers. It drives that port from a registered
// writeback stage and keeps a busy scoreboard for the issue stage.
// Optional feature macro: WB_BYPASS_EN (forwarding of the value in the writeback stage).
//
// Handshake: a transfer from requester i happens on a rising edge where
// req_valid[i] & req_ready[i] is high. req_ready is the grant, which is one-hot
// or zero. The writeback stage never stalls, so the grant is not held back.
// A requester keeps req_valid and its payload stable until it sees the transfer.
`timescale 1ns/1ps
module regfile_writeback_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = 32,
  parameter int SELECT_LEN = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*SELECT_LEN-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  input  logic                          mark_valid,
  input  logic [SELECT_LEN-1:0]         mark_rd,
  input  logic                          flush,
  input  logic [SELECT_LEN-1:0]         query_a,
  input  logic [SELECT_LEN-1:0]         query_b,
  output logic                          busy_a,
  output logic                          busy_b,
`ifdef WB_BYPASS_EN
  output logic                          fwd_a_valid,
  output logic                          fwd_b_valid,
  output logic [XLEN-1:0]               fwd_a_data,
  output logic [XLEN-1:0]               fwd_b_data,
`endif
  output logic                          rf_we,
  output logic [SELECT_LEN-1:0]         rf_store,
  output logic [XLEN-1:0]               rf_store_value,
  output logic [31:0]                   busy_vec
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  found;
  logic [SELECT_LEN-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic [31:0]           sb;
  logic [31:0]           sb_next;

  // Grant search: the first valid requester starting at the pointer, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    found     = 1'b0;
    grant_idx = '0;
    sel_rd    = '0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
        sel_rd     = req_rd[idx*SELECT_LEN +: SELECT_LEN];
        sel_data   = req_data[idx*XLEN +: XLEN];
      end
    end
  end

  assign req_ready = grant;

  // Pointer update and writeback stage. An accepted rd=0 result updates the
  // store fields but never raises the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr            <= '0;
      rf_we          <= 1'b0;
      rf_store       <= '0;
      rf_store_value <= '0;
    end else begin
      rf_we <= found && (sel_rd != '0);
      if (found) begin
        ptr            <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        rf_store       <= sel_rd;
        rf_store_value <= sel_data;
      end
    end
  end

  // Scoreboard next state. A mark overrides both the flush and the writeback
  // clear, because a new producer now owns the register. Bit 0 stays zero.
  always_comb begin
    sb_next = sb;
    if (flush) begin
      sb_next = '0;
    end else if (rf_we) begin
      sb_next[rf_store] = 1'b0;
    end
    if (mark_valid && (mark_rd != '0)) begin
      sb_next[mark_rd] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb <= '0;
    end else begin
      sb <= sb_next;
    end
  end

  assign busy_vec = sb;

`ifdef WB_BYPASS_EN
  logic hit_a;
  logic hit_b;

  // The value in the writeback stage answers a matching query directly.
  always_comb begin
    hit_a       = rf_we && (rf_store == query_a) && (query_a != '0);
    hit_b       = rf_we && (rf_store == query_b) && (query_b != '0);
    busy_a      = sb[query_a] && !hit_a;
    busy_b      = sb[query_b] && !hit_b;
    fwd_a_valid = hit_a;
    fwd_b_valid = hit_b;
    fwd_a_data  = hit_a ? rf_store_value : '0;
    fwd_b_data  = hit_b ? rf_store_value : '0;
  end
`else
  // Without forwarding, a register stays busy until the array holds its value.
  always_comb begin
    busy_a = sb[query_a];
    busy_b = sb[query_b];
  end
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Testbench for regfile_writeback_arbiter (default build, WB_BYPASS_EN undefined).
// Each vector is one clock cycle. Inputs are driven after the falling edge.
// Checks are made 2 ns later: req_ready and busy_a/busy_b follow this cycle's
// inputs, and rf_* and busy_vec show the state left by the earlier rising edges.
`timescale 1ns/1ps
module tb_regfile_writeback_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic        mark_valid;
  logic [4:0]  mark_rd;
  logic        flush;
  logic [4:0]  query_a;
  logic [4:0]  query_b;
  logic        busy_a;
  logic        busy_b;
  logic        rf_we;
  logic [4:0]  rf_store;
  logic [31:0] rf_store_value;
  logic [31:0] busy_vec;

  int n_pass;
  int n_total;

  regfile_writeback_arbiter #(.NUM_REQ(3), .XLEN(32), .SELECT_LEN(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rd         (req_rd),
    .req_data       (req_data),
    .mark_valid     (mark_valid),
    .mark_rd        (mark_rd),
    .flush          (flush),
    .query_a        (query_a),
    .query_b        (query_b),
    .busy_a         (busy_a),
    .busy_b         (busy_b),
    .rf_we          (rf_we),
    .rf_store       (rf_store),
    .rf_store_value (rf_store_value),
    .busy_vec       (busy_vec)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rv;
    logic [14:0] rd;
    logic [95:0] data;
    logic        mv;
    logic [4:0]  mrd;
    logic        fl;
    logic [4:0]  qa;
    logic [4:0]  qb;
    logic [2:0]  e_ready;
    logic        e_we;
    logic [4:0]  e_store;
    logic [31:0] e_val;
    logic [31:0] e_bv;
    logic        e_ba;
    logic        e_bb;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  localparam logic [14:0] RD_RR   = {5'd3, 5'd2, 5'd1};
  localparam logic [95:0] DATA_RR = {32'hA2, 32'hA1, 32'hA0};
  localparam logic [31:0] BEEF    = 32'hDEADBEEF;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid  = v.rv;
    req_rd     = v.rd;
    req_data   = v.data;
    mark_valid = v.mv;
    mark_rd    = v.mrd;
    flush      = v.fl;
    query_a    = v.qa;
    query_b    = v.qb;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset      = 1'b1;
    req_valid  = '0;
    req_rd     = '0;
    req_data   = '0;
    mark_valid = 1'b0;
    mark_rd    = '0;
    flush      = 1'b0;
    query_a    = '0;
    query_b    = '0;

    //            rv      rd              data                        mv    mrd  fl    qa  qb   ready   we    st  val       bv         ba    bb
    vecs[0]  = '{3'b000, 15'd0,           96'd0,                      1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0,    32'h0,     1'b0, 1'b0};
    vecs[1]  = '{3'b000, 15'd0,           96'd0,                      1'b1, 5'd5, 1'b0, 5'd5, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0,    32'h0,     1'b0, 1'b0};
    vecs[2]  = '{3'b010, {5'd0,5'd5,5'd0}, {32'h0,BEEF,32'h0},        1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 3'b010, 1'b0, 5'd0, 32'h0,    32'h20,    1'b1, 1'b0};
    vecs[3]  = '{3'b000, 15'd0,           96'd0,                      1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 3'b000, 1'b1, 5'd5, BEEF,     32'h20,    1'b1, 1'b0};
    vecs[4]  = '{3'b000, 15'd0,           96'd0,                      1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 3'b000, 1'b0, 5'd5, BEEF,     32'h0,     1'b0, 1'b0};
    vecs[5]  = '{3'b111, RD_RR,           DATA_RR,                    1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 3'b100, 1'b0, 5'd5, BEEF,     32'h0,     1'b0, 1'b0};
    vecs[6]  = '{3'b111, RD_RR,           DATA_RR,                    1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 3'b001, 1'b1, 5'd3, 32'hA2,   32'h0,     1'b0, 1'b0};
    vecs[7]  = '{3'b111, RD_RR,           DATA_RR,                    1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 3'b010, 1'b1, 5'd1, 32'hA0,   32'h0,     1'b0, 1'b0};
    vecs[8]  = '{3'b111, RD_RR,           DATA_RR,                    1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 3'b100, 1'b1, 5'd2, 32'hA1,   32'h0,     1'b0, 1'b0};
    vecs[9]  = '{3'b000, 15'd0,           96'd0,                      1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd3, 32'hA2,   32'h0,     1'b0, 1'b0};
    vecs[10] = '{3'b000, 15'd0,           96'd0,                      1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd3, 32'hA2,   32'h0,     1'b0, 1'b0};
    vecs[11] = '{3'b001, 15'd0,           {64'h0,32'h1234},           1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 3'b001, 1'b0, 5'd3, 32'hA2,   32'h0,     1'b0, 1'b0};
    vecs[12] = '{3'b000, 15'd0,           96'd0,                      1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h1234, 32'h0,     1'b0, 1'b0};
    vecs[13] = '{3'b000, 15'd0,           96'd0,                      1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h1234, 32'h0,     1'b0, 1'b0};
    vecs[14] = '{3'b100, {5'd7,10'd0},    {32'h77,64'h0},             1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 3'b100, 1'b0, 5'd0, 32'h1234, 32'h80,    1'b0, 1'b0};
    vecs[15] = '{3'b000, 15'd0,           96'd0,                      1'b1, 5'd7, 1'b0, 5'd7, 5'd0, 3'b000, 1'b1, 5'd7, 32'h77,   32'h80,    1'b1, 1'b0};
    vecs[16] = '{3'b000, 15'd0,           96'd0,                      1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 3'b000, 1'b0, 5'd7, 32'h77,   32'h80,    1'b1, 1'b0};
    vecs[17] = '{3'b000, 15'd0,           96'd0,                      1'b1, 5'd9, 1'b1, 5'd0, 5'd0, 3'b000, 1'b0, 5'd7, 32'h77,   32'h80,    1'b0, 1'b0};
    vecs[18] = '{3'b000, 15'd0,           96'd0,                      1'b0, 5'd0, 1'b0, 5'd9, 5'd7, 3'b000, 1'b0, 5'd7, 32'h77,   32'h200,   1'b1, 1'b0};

    // Reset: held across two rising edges, released after a falling edge
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      check($sformatf("v%0d_ready", i), 96'(req_ready),      96'(vecs[i].e_ready));
      check($sformatf("v%0d_we", i),    96'(rf_we),          96'(vecs[i].e_we));
      check($sformatf("v%0d_store", i), 96'(rf_store),       96'(vecs[i].e_store));
      check($sformatf("v%0d_value", i), 96'(rf_store_value), 96'(vecs[i].e_val));
      check($sformatf("v%0d_busy_vec", i), 96'(busy_vec),    96'(vecs[i].e_bv));
      check($sformatf("v%0d_busy_a", i), 96'(busy_a),        96'(vecs[i].e_ba));
      check($sformatf("v%0d_busy_b", i), 96'(busy_b),        96'(vecs[i].e_bb));
    end

    // Asynchronous reset in mid-stream. The pointer is 0 here, and only requester 1 is valid.
    @(negedge clk);
    req_valid  = 3'b010;
    req_rd     = {5'd0, 5'd6, 5'd0};
    req_data   = {32'h0, 32'h66, 32'h0};
    mark_valid = 1'b1;
    mark_rd    = 5'd6;
    query_a    = 5'd0;
    query_b    = 5'd0;
    #2;
    check("ar_ready_first", 96'(req_ready), 96'(3'b010));
    @(negedge clk);
    mark_valid = 1'b0;
    req_valid  = 3'b111;
    req_rd     = RD_RR;
    req_data   = DATA_RR;
    #1;
    check("ar_ready_ptr2", 96'(req_ready), 96'(3'b100));
    check("ar_we_before", 96'(rf_we), 96'(1'b1));
    check("ar_bv_before", 96'(busy_vec), 96'(32'h240));
    reset = 1'b1;
    #1;
    check("ar_we_reset", 96'(rf_we), 96'(1'b0));
    check("ar_bv_reset", 96'(busy_vec), 96'(32'h0));
    check("ar_store_reset", 96'(rf_store), 96'(5'd0));
    check("ar_value_reset", 96'(rf_store_value), 96'(32'h0));
    reset = 1'b0;
    #1;
    check("ar_ready_after", 96'(req_ready), 96'(3'b001));
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    check("ar_we_after", 96'(rf_we), 96'(1'b1));
    check("ar_store_after", 96'(rf_store), 96'(5'd1));
    check("ar_value_after", 96'(rf_store_value), 96'(32'hA0));

    // The next write comes from requester 1, because the pointer moved past 0
    req_valid = 3'b011;
    #1;
    check("ar_ready_next", 96'(req_ready), 96'(3'b010));
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    check("ar_store_next", 96'(rf_store), 96'(5'd2));

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
